// File: rtl/i3c_pkg.sv
// Shared I3C target-side types: RX descriptor layout, error bit positions,
// RX arbiter states and a saturating counter helper.
package i3c_pkg;

  typedef struct packed {
    logic [3:0]  err;
    logic [11:0] rsvd;
    logic [15:0] len;
  } rx_desc_t;

  localparam int RxErrProducer = 0;
  localparam int RxErrOverflow = 1;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Xfer = 2'd1,
    Desc = 2'd2
  } rx_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      return val;
    end else begin
      return val + 16'd1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester pick starting at a rotating pointer; the pointer moves
// past the released owner when release_i strobes.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            release_i,
  input  logic [IdxW-1:0] release_idx_i,
  output logic            pick_valid_o,
  output logic [IdxW-1:0] pick_idx_o
);

  logic [IdxW-1:0] ptr_r;

  // Pointer register: next search starts just after the last owner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r <= '0;
    end else if (release_i) begin
      if (release_idx_i == IdxW'(N - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= release_idx_i + IdxW'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // First active requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx          = 0;
    pick_valid_o = 1'b0;
    pick_idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      idx = 32'(ptr_r) + 32'(k);
      if (idx >= 32'(N)) begin
        idx = idx - 32'(N);
      end else begin
        idx = idx;
      end
      if (!pick_valid_o && req_i[idx]) begin
        pick_valid_o = 1'b1;
        pick_idx_o   = IdxW'(idx);
      end else begin
        pick_valid_o = pick_valid_o;
      end
    end
  end

endmodule

// File: rtl/tti_rx_arbiter.sv
// Shares the TTI RX data and descriptor queues between byte producers: one
// locked grant per transfer, byte counting, overflow tracking, descriptor commit.
module tti_rx_arbiter
  import i3c_pkg::*;
#(
  parameter int NumReq             = 2,
  parameter int TtiRxDescDataWidth = 32,
  parameter int TtiRxDataWidth     = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReq*TtiRxDataWidth-1:0]   req_byte_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  input  logic [NumReq-1:0]                  req_last_i,
  input  logic [NumReq-1:0]                  req_err_i,
  output logic [NumReq-1:0]                  req_ready_o,
  output logic [NumReq-1:0]                  req_grant_o,
  output logic                               tti_rx_queue_wvalid_o,
  output logic [TtiRxDataWidth-1:0]          tti_rx_queue_wdata_o,
  input  logic                               tti_rx_queue_wready_i,
  output logic                               tti_rx_queue_flush_o,
  output logic                               tti_rx_desc_queue_wvalid_o,
  output logic [TtiRxDescDataWidth-1:0]      tti_rx_desc_queue_wdata_o,
  input  logic                               tti_rx_desc_queue_wready_i,
  output logic                               overflow_o
);

  localparam int IdxW = $clog2(NumReq);

  rx_state_e         state_r, state_s;
  logic [IdxW-1:0]   owner_r, owner_s;
  logic [NumReq-1:0] grant_r, grant_s;
  logic [15:0]       count_r, count_s;
  logic              ovf_r, ovf_s;
  rx_desc_t          desc_r, desc_s;

  logic [NumReq-1:0] active_s;
  logic              pick_valid_s;
  logic [IdxW-1:0]   pick_idx_s;
  logic              release_s;
  logic              g_valid_s, g_last_s, g_err_s;

  assign active_s  = req_valid_i | req_last_i | req_err_i;
  assign g_valid_s = req_valid_i[owner_r];
  assign g_last_s  = req_last_i[owner_r];
  assign g_err_s   = req_err_i[owner_r];

  rr_arbiter #(.N(NumReq)) u_rr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (active_s),
    .release_i    (release_s),
    .release_idx_i(owner_r),
    .pick_valid_o (pick_valid_s),
    .pick_idx_o   (pick_idx_s)
  );

  // Transfer state, owner, byte count, overflow flag and descriptor.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= Idle;
      owner_r <= '0;
      grant_r <= '0;
      count_r <= 16'd0;
      ovf_r   <= 1'b0;
      desc_r  <= '0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      grant_r <= grant_s;
      count_r <= count_s;
      ovf_r   <= ovf_s;
      desc_r  <= desc_s;
    end
  end

  // Next-state and queue-side handshakes.
  always_comb begin
    state_s                    = state_r;
    owner_s                    = owner_r;
    grant_s                    = grant_r;
    count_s                    = count_r;
    ovf_s                      = ovf_r;
    desc_s                     = desc_r;
    release_s                  = 1'b0;
    req_ready_o                = '0;
    tti_rx_queue_wvalid_o      = 1'b0;
    tti_rx_queue_wdata_o       = '0;
    tti_rx_queue_flush_o       = 1'b0;
    tti_rx_desc_queue_wvalid_o = 1'b0;
    case (state_r)
      Idle: begin
        if (pick_valid_s) begin
          owner_s = pick_idx_s;
          grant_s = NumReq'(1'b1) << pick_idx_s;
          state_s = Xfer;
        end else begin
          state_s = Idle;
        end
      end
      Xfer: begin
        req_ready_o[owner_r]  = tti_rx_queue_wready_i;
        tti_rx_queue_wdata_o  = req_byte_i[owner_r*TtiRxDataWidth +: TtiRxDataWidth];
        tti_rx_queue_wvalid_o = g_valid_s & tti_rx_queue_wready_i & ~g_err_s;
        if (tti_rx_queue_wvalid_o) begin
          count_s = sat_inc16(count_r);
        end else begin
          count_s = count_r;
        end
        // An errored byte is discarded by the error path, not counted as overflow.
        if (g_valid_s && !tti_rx_queue_wready_i && !g_err_s) begin
          ovf_s = 1'b1;
        end else begin
          ovf_s = ovf_r;
        end
        if (g_last_s || g_err_s) begin
          desc_s                     = '0;
          desc_s.err[RxErrProducer]  = g_err_s;
          desc_s.err[RxErrOverflow]  = ovf_s;
          desc_s.len                 = count_s;
          state_s                    = Desc;
          release_s                  = 1'b1;
        end else begin
          state_s = Xfer;
        end
      end
      Desc: begin
        tti_rx_desc_queue_wvalid_o = 1'b1;
        if (tti_rx_desc_queue_wready_i) begin
          tti_rx_queue_flush_o = 1'b1;
          count_s              = 16'd0;
          ovf_s                = 1'b0;
          desc_s               = '0;
          grant_s              = '0;
          state_s              = Idle;
        end else begin
          state_s = Desc;
        end
      end
      default: begin
        state_s = Idle;
      end
    endcase
  end

  assign req_grant_o               = grant_r;
  assign overflow_o                = ovf_r;
  assign tti_rx_desc_queue_wdata_o = TtiRxDescDataWidth'(desc_r);

endmodule

// File: tb/tb_tti_rx_arbiter.sv
// Randomized bench for tti_rx_arbiter: per-transfer reference model predicting
// accepted bytes, descriptor contents and round-robin service order.
module tb_tti_rx_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] req_byte_i;
  logic [1:0]  req_valid_i, req_last_i, req_err_i;
  logic [1:0]  req_ready_o, req_grant_o;
  logic        tti_rx_queue_wvalid_o;
  logic [7:0]  tti_rx_queue_wdata_o;
  logic        tti_rx_queue_wready_i;
  logic        tti_rx_queue_flush_o;
  logic        tti_rx_desc_queue_wvalid_o;
  logic [31:0] tti_rx_desc_queue_wdata_o;
  logic        tti_rx_desc_queue_wready_i;
  logic        overflow_o;

  int errors = 0;
  int checks = 0;

  tti_rx_arbiter #(.NumReq(2), .TtiRxDescDataWidth(32), .TtiRxDataWidth(8)) dut (
    .clk_i                     (clk_i),
    .rst_i                     (rst_i),
    .req_byte_i                (req_byte_i),
    .req_valid_i               (req_valid_i),
    .req_last_i                (req_last_i),
    .req_err_i                 (req_err_i),
    .req_ready_o               (req_ready_o),
    .req_grant_o               (req_grant_o),
    .tti_rx_queue_wvalid_o     (tti_rx_queue_wvalid_o),
    .tti_rx_queue_wdata_o      (tti_rx_queue_wdata_o),
    .tti_rx_queue_wready_i     (tti_rx_queue_wready_i),
    .tti_rx_queue_flush_o      (tti_rx_queue_flush_o),
    .tti_rx_desc_queue_wvalid_o(tti_rx_desc_queue_wvalid_o),
    .tti_rx_desc_queue_wdata_o (tti_rx_desc_queue_wdata_o),
    .tti_rx_desc_queue_wready_i(tti_rx_desc_queue_wready_i),
    .overflow_o                (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transfer from requester r: n bytes (base + 0x11*k), ending with last on
  // byte n-1, or with an extra errored byte when end_err. Bit k of drop_mask
  // holds the data queue full for byte k. hold_other raises the other
  // requester with byte 0xA0 in the same cycle as r's first byte.
  task automatic run_xfer(input int r, input int n, input bit end_err, input int drop_mask,
                          input int desc_delay, input bit hold_other, output int wait_cyc);
    int          len;
    bit          ovf;
    bit          got;
    int          steps;
    logic [7:0]  b;
    logic [1:0]  exp_rdy;
    logic [1:0]  onehot;
    logic [31:0] exp_desc;
    len = 0; ovf = 1'b0; got = 1'b0; wait_cyc = 0;
    onehot = 2'b01 << r;
    steps = end_err ? n + 1 : n;
    @(posedge clk_i); #1;
    if (hold_other) begin
      req_valid_i[1-r] = 1'b1;
      req_byte_i[(1-r)*8 +: 8] = 8'hA0;
    end
    for (int k = 0; k < steps; k++) begin
      b = 8'h11 + 8'(17 * k);
      req_byte_i[r*8 +: 8] = b;
      req_valid_i[r] = 1'b1;
      req_last_i[r]  = !end_err && (k == n - 1);
      req_err_i[r]   = end_err && (k == n);
      tti_rx_queue_wready_i = req_err_i[r] ? 1'b1 : !drop_mask[k];
      if (k == 0) begin
        for (int c = 0; c < 20 && !got; c++) begin
          @(negedge clk_i);
          if (req_grant_o[r]) got = 1'b1;
          else begin
            wait_cyc++;
            @(posedge clk_i); #1;
          end
        end
        check_eq("grant_rise", 32'(got), 32'd1);
      end else begin
        @(negedge clk_i);
      end
      check_eq("grant_owner", 32'(req_grant_o), 32'(onehot));
      exp_rdy = tti_rx_queue_wready_i ? onehot : 2'b00;
      check_eq("ready", 32'(req_ready_o), 32'(exp_rdy));
      if (req_err_i[r]) begin
        check_eq("wvalid_err", 32'(tti_rx_queue_wvalid_o), 32'd0);
      end else if (tti_rx_queue_wready_i) begin
        check_eq("wvalid", 32'(tti_rx_queue_wvalid_o), 32'd1);
        check_eq("wdata", 32'(tti_rx_queue_wdata_o), 32'(b));
        len++;
      end else begin
        check_eq("wvalid_drop", 32'(tti_rx_queue_wvalid_o), 32'd0);
        ovf = 1'b1;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i[r] = 1'b0; req_last_i[r] = 1'b0; req_err_i[r] = 1'b0;
    tti_rx_queue_wready_i = 1'b1;
    exp_desc = {2'b00, ovf, end_err, 12'h000, 16'(len)};
    for (int c = 0; c <= desc_delay; c++) begin
      tti_rx_desc_queue_wready_i = (c == desc_delay);
      @(negedge clk_i);
      check_eq("desc_wvalid", 32'(tti_rx_desc_queue_wvalid_o), 32'd1);
      check_eq("desc_wdata", tti_rx_desc_queue_wdata_o, exp_desc);
      check_eq("flush", 32'(tti_rx_queue_flush_o), 32'(c == desc_delay));
      check_eq("ready_desc", 32'(req_ready_o), 32'd0);
      check_eq("grant_desc", 32'(req_grant_o), 32'(onehot));
      check_eq("overflow", 32'(overflow_o), 32'(ovf));
      @(posedge clk_i); #1;
    end
    tti_rx_desc_queue_wready_i = 1'b0;
    @(negedge clk_i);
    check_eq("grant_drop", 32'(req_grant_o), 32'd0);
    check_eq("overflow_clr", 32'(overflow_o), 32'd0);
    check_eq("desc_idle", 32'(tti_rx_desc_queue_wvalid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  got;
    int  n;
    bit  e;
    rst_i = 1'b1;
    req_byte_i = '0; req_valid_i = '0; req_last_i = '0; req_err_i = '0;
    tti_rx_queue_wready_i = 1'b1;
    tti_rx_desc_queue_wready_i = 1'b0;
    #12;
    check_eq("rst_grant", 32'(req_grant_o), 32'd0);
    check_eq("rst_ready", 32'(req_ready_o), 32'd0);
    check_eq("rst_wvalid", 32'(tti_rx_queue_wvalid_o), 32'd0);
    check_eq("rst_wdata", 32'(tti_rx_queue_wdata_o), 32'd0);
    check_eq("rst_desc_wvalid", 32'(tti_rx_desc_queue_wvalid_o), 32'd0);
    check_eq("rst_desc_wdata", tti_rx_desc_queue_wdata_o, 32'd0);
    check_eq("rst_flush", 32'(tti_rx_queue_flush_o), 32'd0);
    check_eq("rst_overflow", 32'(overflow_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    run_xfer(0, 4, 1'b0, 0, 0, 1'b0, w);       // 0x11..0x44, desc 0x0000_0004
    run_xfer(1, 3, 1'b0, 32'b010, 0, 1'b0, w); // 2nd byte dropped, desc 0x2000_0002
    run_xfer(1, 5, 1'b1, 0, 1, 1'b0, w);       // err with a byte, desc 0x1000_0005
    // Pointer at 0, both requesters active together, descriptor stalled 10 cycles.
    run_xfer(0, 2, 1'b0, 0, 10, 1'b1, w);
    run_xfer(1, 3, 1'b0, 0, 0, 1'b0, w);
    check_eq("rr_no_extra_idle", 32'(w), 32'd0);
    run_xfer(0, 1, 1'b0, 0, 0, 1'b1, w);       // pointer back at 0
    run_xfer(1, 2, 1'b1, 32'b01, 0, 1'b0, w);  // err plus overflow, desc 0x3000_0001

    // Reset in the middle of a transfer from requester 0 with a dropped byte.
    run_xfer(0, 1, 1'b0, 0, 0, 1'b0, w);       // leaves pointer at 1
    @(posedge clk_i); #1;
    req_valid_i[0] = 1'b1; req_byte_i[7:0] = 8'h55; tti_rx_queue_wready_i = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk_i);
      if (req_grant_o[0]) got = 1'b1;
      else begin
        @(posedge clk_i); #1;
      end
    end
    check_eq("rst_xfer_grant", 32'(got), 32'd1);
    @(posedge clk_i); #1;
    req_byte_i[7:0] = 8'h66; tti_rx_queue_wready_i = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i[0] = 1'b0; tti_rx_queue_wready_i = 1'b1;
    @(negedge clk_i);
    check_eq("rst_xfer_ovf", 32'(overflow_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_eq("midrst_grant", 32'(req_grant_o), 32'd0);
    check_eq("midrst_overflow", 32'(overflow_o), 32'd0);
    check_eq("midrst_desc", 32'(tti_rx_desc_queue_wvalid_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("postrst_desc", 32'(tti_rx_desc_queue_wvalid_o), 32'd0);
    run_xfer(0, 3, 1'b0, 0, 0, 1'b1, w);       // pointer reset to 0, length from 0
    run_xfer(1, 1, 1'b0, 0, 0, 1'b0, w);

    // Randomized single-requester transfers.
    for (int t = 0; t < 40; t++) begin
      e = ($urandom_range(0, 3) == 0);
      n = e ? $urandom_range(0, 5) : $urandom_range(1, 6);
      run_xfer($urandom_range(0, 1), n, e, int'($urandom & $urandom & 32'h3F),
               $urandom_range(0, 3), 1'b0, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tti_rx_arbiter.md
Name: tti_rx_arbiter

Overview:
- Shares the single TTI RX data queue and RX descriptor queue between NumReq byte producers, e.g. the private-write target FSM and the CCC direct-write handler.
- Grants the queues to one producer per transfer, using round-robin arbitration with the grant locked until the transfer ends.
- Counts the bytes of each transfer, detects data-queue overflow, and builds and commits one RX descriptor per transfer.
- Sits between the target-side protocol FSMs and the TTI queues.

Parameters:
- NumReq, 2, number of byte producers; must be at least 2.
- TtiRxDescDataWidth, 32, descriptor width.
- TtiRxDataWidth, 8, data queue word width; must equal 8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- req_byte_i  in  NumReq x 8  per-producer data byte
- req_valid_i  in  NumReq  byte strobe; held for one cycle per byte
- req_last_i  in  NumReq  end of transfer; qualifies the byte in the same cycle if valid is high, otherwise it is a zero-byte end
- req_err_i  in  NumReq  producer error; ends the transfer, and any byte in the same cycle is dropped
- req_ready_o  out  NumReq  queue can accept a byte for this producer
- req_grant_o  out  NumReq  one-hot owner of the queues
- tti_rx_queue_wvalid_o  out  1  data write strobe
- tti_rx_queue_wdata_o  out  8  data byte
- tti_rx_queue_wready_i  in  1  data queue not full
- tti_rx_queue_flush_o  out  1  one-cycle pulse when a descriptor is accepted
- tti_rx_desc_queue_wvalid_o  out  1  descriptor valid
- tti_rx_desc_queue_wdata_o  out  TtiRxDescDataWidth  descriptor
- tti_rx_desc_queue_wready_i  in  1  descriptor queue not full
- overflow_o  out  1  sticky per transfer: a byte was dropped

Behaviour:
- Reset: state IDLE, round-robin pointer 0; every output 0, including the byte counter, the error flags and the descriptor register.
- Activity of requester i is defined as any of req_valid_i[i], req_last_i[i] or req_err_i[i] being high.
- IDLE:
  - Select the first active requester at or after the pointer, wrapping.
  - Set its grant in the next cycle and go to XFER.
  - Inputs in the selection cycle are not consumed; producers must hold the first byte until the grant rises.
  - A producer that cannot stall may lose that byte; this is a documented limitation.
- XFER, for the granted requester g:
  - req_ready_o[g] = tti_rx_queue_wready_i. Every other requester's ready is 0.
  - tti_rx_queue_wvalid_o = req_valid_i[g] & tti_rx_queue_wready_i & ~req_err_i[g]. wdata is a combinational pass-through of req_byte_i[g].
  - Each accepted byte increments the 16-bit counter, which saturates at 0xFFFF.
  - A byte with valid high and wready low is dropped: the counter does not change and the overflow flag is set.
  - Activity from non-granted requesters is ignored; their bytes are lost.
- End of transfer: last or err from g.
  - In the next cycle, register the descriptor = {err[3:0], 12'b0, count[15:0]}.
  - count includes a byte accepted in the same cycle as last.
  - err[0] = producer error; err[1] = overflow; err[3:2] = 0.
  - Go to DESC and advance the pointer to g+1 mod NumReq.
- DESC:
  - tti_rx_desc_queue_wvalid_o is high and its data is stable until wready.
  - All ready outputs are 0; g's grant stays high.
  - On wvalid & wready: pulse flush, clear the counter and flags, drop the grant, go to IDLE.
  - The descriptor appears on the interface one cycle after the last beat.
- Simultaneous last and err: err wins, so the descriptor error is 0001, or 0011 if an overflow also occurred.
- The descriptor queue may stay full indefinitely; the block holds in DESC without a timeout.
- Reset asserted mid-transfer: return immediately to the reset state; no descriptor is emitted.
- overflow_o is high from the first dropped byte until the descriptor is accepted.

Decomposition:
- Shared package i3c_pkg:
  - rx_desc_t packed struct {err[3:0], rsvd[11:0], len[15:0]}
  - error bit constants RxErrProducer=0 and RxErrOverflow=1
  - state enum {Idle, Xfer, Desc}
- Sub-module rr_arbiter: parameterised round-robin pick with pointer update on a grant-release strobe, reusable elsewhere.

Test Plan:
- Requester 0 sends 4 bytes 0x11..0x44 with last on the 4th, both queues ready → 4 data writes; descriptor 0x0000_0004 one cycle after last; flush pulses once.
- Requester 0 and requester 1 become active in the same cycle, pointer at 0 → requester 0 is served; after its descriptor is accepted, requester 1 is granted with no extra idle cycle beyond IDLE selection; the pointer then returns to 0.
- wready is low for the 2nd of 3 bytes → 2 data writes; overflow_o rises; descriptor 0x2000_0002.
- Requester 1 asserts err after 5 bytes, with a byte in the same cycle → that byte is not written; descriptor 0x1000_0005.
- Descriptor wready is held low for 10 cycles → wvalid and data are stable, ready outputs stay 0, and new requests wait; acceptance on cycle 11 gives flush.
- rst_i is pulsed after 2 bytes of a transfer → no descriptor; grant, counter and overflow flag are 0; the next transfer reports a length counting from 0.
